inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Boot-time writer for the instruction memory. The fetch path only ever reads instruction memory; this block fills it.
- Receives a framed little-endian byte stream through a valid/ready handshake and assembles it into 32-bit instruction words. Each word is written into instruction memory through a single-cycle write port.
- Holds the CPU in reset while loading. Reports completion and checksum status.
- Sits between the host/UART byte source and the write port of the instruction memory.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be word-aligned.
- ADDR_W, 32, width of WrAddr (byte address); the memory indexes WrAddr[17:2].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- ByteIn  in  8  stream byte.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts a byte this cycle; transfer = ByteValid & ByteReady.
- WrEn  out  1  instruction-memory write strobe, one cycle per word.
- WrAddr  out  ADDR_W  byte address of the word being written.
- WrData  out  32  assembled instruction word.
- CpuHold  out  1  high while a load is in progress; the CPU is held in reset.
- Busy  out  1  high in any state other than IDLE and DONE.
- Done  out  1  one-cycle pulse when the frame ends.
- Error  out  1  checksum mismatch; level, cleared on next Start.

Behaviour:
- Reset values: all outputs 0, state IDLE, address = BASE_ADDR, checksum accumulator = 0, byte index = 0.
- Frame format, in order:
  - LEN0, LEN1: word count N, 16-bit little-endian.
  - 4*N data bytes, each word little-endian (first byte = bits [7:0]).
  - One checksum byte equal to the XOR of all preceding frame bytes (LEN0 through the last data byte).
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE.
- IDLE/DONE + Start → LEN0. On Start: clear Error, clear accumulator, clear byte index, WrAddr counter = BASE_ADDR.
- ByteReady = 1 in LEN0, LEN1, DATA, CSUM; 0 otherwise. CpuHold = Busy.
- Only transfer cycles advance state. Gaps in ByteValid stall without side effects.
- LEN0 → LEN1 on transfer.
- LEN1 → DATA on transfer if N ≠ 0; → CSUM if N = 0.
- DATA:
  - Each transfer shifts the byte into the assembly register at lane = byte index.
  - On the 4th byte of a word, the next cycle shows: WrEn=1, WrData=assembled word, WrAddr=current address. In that same cycle the address advances by 4.
  - Latency: last byte accepted → WrEn exactly 1 cycle later.
  - After the 4th byte of word N-1 → CSUM.
  - A new byte may be accepted in the same cycle as the WrEn of the previous word (full throughput, 1 byte/cycle).
- CSUM: on transfer, Error ← (ByteIn ≠ accumulator); → DONE; Done pulses 1 cycle after the checksum byte is accepted.
- The accumulator XORs every accepted byte except the checksum byte.
- WrAddr wraps modulo 2^ADDR_W. No overflow check.
- Start while Busy: ignored.
- Start in the same cycle as a transfer in DONE: not possible, since ByteReady=0 in DONE.
- Reset mid-load: immediate return to IDLE. Partially written memory is not rolled back. CpuHold drops, and software must reload.
- Error stays valid from Done until the next Start.

Decomposition:
- Shared package `loader_pkg`: state encoding enum, frame-field constants (LEN_BYTES=2, WORD_BYTES=4).
- Sub-module `word_assembler`: byte-to-word shifter with lane counter and a word_ready pulse.
- The FSM, address counter and checksum live in the top module.

Test Plan:
- Start; bytes 02 00 14 00 A0 E3 01 1A A0 E3 0D, valid every cycle → WrEn at addr 0 with E3A00014, WrEn at addr 4 with E3A01A01; Done pulse; Error=0; CpuHold high from LEN0 until DONE.
- Same frame with checksum byte 0x0C → both words written, Done pulse, Error=1; next Start clears Error to 0.
- Frame 00 00 00 (N=0) → no WrEn, Done pulse, Error=0.
- Same frame as the first scenario with ByteValid dropped for 3 cycles between every byte → identical writes and data; WrEn exactly 1 cycle after each 4th byte.
- Assert rst after the 6th byte of the first frame → all outputs 0, state IDLE; a fresh Start plus full frame writes both words again at addr 0 and 4.
- Pulse Start during DATA → ignored: no address reset, writes continue at the correct addresses.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: frame field sizes
// and the loader state encoding.
package loader_pkg;

   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_CSUM,
      ST_DONE
   } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs little-endian stream bytes into 32-bit words; word_ready pulses for one
// cycle with the completed word on the cycle after its fourth byte.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        last_lane,
   output logic [31:0] word,
   output logic        word_ready
);

   logic [1:0]  lane;
   logic [23:0] partial;

   assign last_lane = (lane == 2'(WORD_BYTES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lane       <= '0;
         partial    <= '0;
         word       <= '0;
         word_ready <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so lane and partial update coherently.
         word_ready <= 1'b0;
         if (clear) begin
            lane <= '0;
         end else if (byte_en) begin
            lane <= lane + 2'd1;
            if (last_lane) begin
               word       <= {byte_in, partial};
               word_ready <= 1'b1;
            end else begin
               partial[8*lane +: 8] <= byte_in;
            end
         end
      end
   end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time instruction-memory writer: parses a length/data/checksum byte frame,
// writes each assembled word and holds the CPU in reset while loading.
module inst_mem_loader
   import loader_pkg::*;
#(
   parameter int unsigned           ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Start,
   input  logic [7:0]        ByteIn,
   input  logic              ByteValid,
   output logic              ByteReady,
   output logic              WrEn,
   output logic [ADDR_W-1:0] WrAddr,
   output logic [31:0]       WrData,
   output logic              CpuHold,
   output logic              Busy,
   output logic              Done,
   output logic              Error
);

   localparam int CNT_W = 8 * LEN_BYTES;

   state_t             state;
   logic [7:0]         len_lo;
   logic [7:0]         acc;
   logic [CNT_W-1:0]   words_left;
   logic [ADDR_W-1:0]  addr;
   logic               xfer;
   logic               start_ok;
   logic               data_xfer;
   logic               last_lane;
   logic               word_ready;
   logic [31:0]        word;
   logic [CNT_W-1:0]   len_word;

   assign ByteReady = (state == ST_LEN0) || (state == ST_LEN1) ||
                      (state == ST_DATA) || (state == ST_CSUM);
   assign Busy      = ByteReady;
   assign CpuHold   = Busy;
   assign xfer      = ByteValid & ByteReady;
   assign start_ok  = Start & ((state == ST_IDLE) || (state == ST_DONE));
   assign data_xfer = xfer & (state == ST_DATA);
   assign len_word  = {ByteIn, len_lo};

   assign WrEn   = word_ready;
   assign WrData = word;
   assign WrAddr = addr;

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_ok),
      .byte_en    (data_xfer),
      .byte_in    (ByteIn),
      .last_lane  (last_lane),
      .word       (word),
      .word_ready (word_ready)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         len_lo     <= '0;
         acc        <= '0;
         words_left <= '0;
         addr       <= BASE_ADDR;
         Done       <= 1'b0;
         Error      <= 1'b0;
      end else begin
         Done <= 1'b0;
         // The address steps in the same cycle its word is presented on WrAddr.
         if (word_ready)
            addr <= addr + ADDR_W'(WORD_BYTES);

         case (state)
            ST_IDLE, ST_DONE: begin
               if (Start) begin
                  state <= ST_LEN0;
                  Error <= 1'b0;
                  acc   <= '0;
                  addr  <= BASE_ADDR;
               end
            end
            ST_LEN0: begin
               if (xfer) begin
                  len_lo <= ByteIn;
                  acc    <= acc ^ ByteIn;
                  state  <= ST_LEN1;
               end
            end
            ST_LEN1: begin
               if (xfer) begin
                  acc        <= acc ^ ByteIn;
                  words_left <= len_word;
                  state      <= (len_word == '0) ? ST_CSUM : ST_DATA;
               end
            end
            ST_DATA: begin
               if (xfer) begin
                  acc <= acc ^ ByteIn;
                  if (last_lane) begin
                     words_left <= words_left - CNT_W'(1);
                     if (words_left == CNT_W'(1))
                        state <= ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               if (xfer) begin
                  Error <= (ByteIn != acc);
                  Done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized and directed bench for inst_mem_loader, checked against a
// frame-level reference model and a scoreboard of expected memory writes.
module tb_inst_mem_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        Start = 1'b0;
   logic [7:0]  ByteIn = 8'h00;
   logic        ByteValid = 1'b0;
   logic        ByteReady, WrEn, CpuHold, Busy, Done, Error;
   logic [31:0] WrAddr, WrData;

   inst_mem_loader #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .rst       (rst),
      .Start     (Start),
      .ByteIn    (ByteIn),
      .ByteValid (ByteValid),
      .ByteReady (ByteReady),
      .WrEn      (WrEn),
      .WrAddr    (WrAddr),
      .WrData    (WrData),
      .CpuHold   (CpuHold),
      .Busy      (Busy),
      .Done      (Done),
      .Error     (Error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   done_seen = 0;
   wr_t  exp_wr[$];
   logic frame_err = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: tracks frame position from the bytes the bench offered.
   logic       m_busy = 1'b0;
   int         m_pos = 0;
   int         m_n = 0;
   logic [7:0] m_len_lo = 8'h00;
   logic       m_wr_due = 1'b0;
   logic       m_done_due = 1'b0;
   logic       m_err = 1'b0;

   always @(negedge clk) begin
      wr_t w;
      if (!rst) begin
         check("rst_quiet", 64'(|{ByteReady, WrEn, WrAddr, WrData, CpuHold, Busy, Done, Error}), 64'd0);
         m_busy = 1'b0; m_wr_due = 1'b0; m_done_due = 1'b0; m_err = 1'b0;
         exp_wr.delete();
      end else begin
         check("busy", 64'(Busy), 64'(m_busy));
         check("cpuhold", 64'(CpuHold), 64'(m_busy));
         check("ready", 64'(ByteReady), 64'(m_busy));
         check("error", 64'(Error), 64'(m_err));
         if (WrEn || m_wr_due) begin
            check("wr_en", 64'(WrEn), 64'(m_wr_due));
            if (WrEn) begin
               if (exp_wr.size() == 0) begin
                  check("wr_unexpected", 64'd1, 64'd0);
               end else begin
                  w = exp_wr.pop_front();
                  check("wr_addr", 64'(WrAddr), 64'(w.addr));
                  check("wr_data", 64'(WrData), 64'(w.data));
               end
            end
         end
         if (Done || m_done_due) check("done", 64'(Done), 64'(m_done_due));
         if (Done) done_seen++;

         m_wr_due = 1'b0;
         m_done_due = 1'b0;
         if (m_busy && ByteValid) begin
            if (m_pos == 0) m_len_lo = ByteIn;
            else if (m_pos == 1) m_n = int'({ByteIn, m_len_lo});
            else if (m_pos < 2 + 4 * m_n) m_wr_due = (((m_pos - 2) % 4) == 3);
            else begin
               m_done_due = 1'b1;
               m_busy = 1'b0;
               m_err = frame_err;
            end
            m_pos++;
         end else if (!m_busy && Start) begin
            m_busy = 1'b1;
            m_pos = 0;
            m_err = 1'b0;
         end
      end
   end

   // gap < 0 selects a random 0..3 idle cycles before each byte.
   task automatic run_frame(input logic [7:0] fr[$], input int gap,
                            input int start_at, input int abort_after);
      int n, d0, g;
      logic [7:0] x;
      n = int'({fr[1], fr[0]});
      x = 8'h00;
      for (int i = 0; i < fr.size() - 1; i++) x ^= fr[i];
      frame_err = (fr[fr.size() - 1] != x);
      for (int i = 0; i < n; i++)
         exp_wr.push_back('{addr: BASE + 32'(4 * i),
                            data: {fr[4*i+5], fr[4*i+4], fr[4*i+3], fr[4*i+2]}});
      d0 = done_seen;
      Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      for (int i = 0; i < fr.size(); i++) begin
         g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
         repeat (g) begin
            ByteValid = 1'b0;
            @(posedge clk); #1;
         end
         ByteValid = 1'b1;
         ByteIn = fr[i];
         Start = (i == start_at);
         @(posedge clk); #1;
         ByteValid = 1'b0;
         Start = 1'b0;
         if (i + 1 == abort_after) begin
            rst = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            return;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      check("frame_done", 64'(done_seen - d0), 64'd1);
      check("wr_left", 64'(exp_wr.size()), 64'd0);
   endtask

   task automatic rand_frame(output logic [7:0] fr[$]);
      int n;
      logic [7:0] x, b;
      fr.delete();
      n = $urandom_range(0, 5);
      fr.push_back(8'(n));
      fr.push_back(8'h00);
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom);
         fr.push_back(b);
      end
      x = 8'h00;
      foreach (fr[i]) x ^= fr[i];
      if ($urandom_range(0, 3) == 0) x ^= 8'(1 + $urandom_range(0, 254));
      fr.push_back(x);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] f_good[$], f_bad[$], f_zero[$], f_rand[$];
      f_good = '{8'h02, 8'h00, 8'h14, 8'h00, 8'hA0, 8'hE3,
                 8'h01, 8'h1A, 8'hA0, 8'hE3, 8'h0D};
      f_bad = f_good;
      f_bad[10] = 8'h0C;
      f_zero = '{8'h00, 8'h00, 8'h00};

      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      check("reset_addr", 64'(WrAddr), 64'(BASE));

      run_frame(f_good, 0, -1, -1);
      run_frame(f_bad, 0, -1, -1);
      run_frame(f_good, 0, -1, -1);
      run_frame(f_zero, 0, -1, -1);
      run_frame(f_good, 3, -1, -1);
      run_frame(f_good, 0, -1, 6);
      run_frame(f_good, 0, -1, -1);
      run_frame(f_good, 0, 7, -1);
      run_frame(f_good, -1, 4, -1);

      for (int k = 0; k < 40; k++) begin
         rand_frame(f_rand);
         run_frame(f_rand, -1, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
